// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue unit: ALU command codes, datapath widths, FSM encoding.
package alu_issue_pkg;

    localparam int CMD_W  = 3;
    localparam int DATA_W = 32;

    localparam logic [CMD_W-1:0] CMD_ADD  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_SUB  = 3'd1;
    localparam logic [CMD_W-1:0] CMD_XOR  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_SLT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_AND  = 3'd4;
    localparam logic [CMD_W-1:0] CMD_NAND = 3'd5;
    localparam logic [CMD_W-1:0] CMD_NOR  = 3'd6;
    localparam logic [CMD_W-1:0] CMD_OR   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with first-word fall-through read and asynchronous active-high reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit: queues tagged ALU requests, holds operands stable for a settle window, returns results.
// Optional feature macro ALU_STICKY_FLAGS_EN adds sticky carry/overflow flag ports.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [CMD_W-1:0]  alu_command,
    output logic [DATA_W-1:0] alu_operandA,
    output logic [DATA_W-1:0] alu_operandB,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carryout,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carryout,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic              sticky_clr,
    output logic              sticky_cout,
    output logic              sticky_ovf
`endif
);
    localparam int REQ_W = CMD_W + 2 * DATA_W + TAG_W;
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

    issue_state_e      r_state;
    issue_state_e      w_next_state;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_cnt_dec;
    logic              w_capture;
    logic              w_rsp_done;
    logic [REQ_W-1:0]  w_push_data;
    logic [REQ_W-1:0]  w_pop_data;
    logic [CMD_W-1:0]  w_pop_cmd;
    logic [DATA_W-1:0] w_pop_a;
    logic [DATA_W-1:0] w_pop_b;
    logic [TAG_W-1:0]  w_pop_tag;

    logic              r_ready_en;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [TAG_W-1:0]  r_tag;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_carryout;
    logic              r_rsp_zero;
    logic              r_rsp_overflow;
    logic [TAG_W-1:0]  r_rsp_tag;

    // req_ready stays low through reset and for the first clock after release.
    assign req_ready   = r_ready_en && !w_full;
    assign w_push      = req_valid && req_ready;
    assign w_push_data = {req_cmd, req_a, req_b, req_tag};
    assign {w_pop_cmd, w_pop_a, w_pop_b, w_pop_tag} = w_pop_data;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = w_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_cnt_dec  = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = !w_empty;
            end
            ST_ISSUE: begin
                w_cnt_dec = (r_cnt != '0);
                w_capture = (r_cnt == '0);
            end
            ST_RESP: begin
                w_rsp_done = rsp_ready;
                w_pop      = rsp_ready && !w_empty;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // Drive registers keep their last value while idle so the ALU inputs never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready_en <= 1'b0;
            r_cmd      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_tag      <= '0;
            r_cnt      <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_pop) begin
                r_cmd <= w_pop_cmd;
                r_a   <= w_pop_a;
                r_b   <= w_pop_b;
                r_tag <= w_pop_tag;
                r_cnt <= CNT_LOAD;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_carryout <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_tag      <= '0;
        end else if (w_capture) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= alu_result;
            r_rsp_carryout <= alu_carryout;
            r_rsp_zero     <= alu_zero;
            r_rsp_overflow <= alu_overflow;
            r_rsp_tag      <= r_tag;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign alu_command  = r_cmd;
    assign alu_operandA = r_a;
    assign alu_operandB = r_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_carryout = r_rsp_carryout;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_tag      = r_rsp_tag;

`ifdef ALU_STICKY_FLAGS_EN
    logic r_sticky_cout;
    logic r_sticky_ovf;

    // A capture that sees the flag set takes priority over a same-edge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky_cout <= 1'b0;
            r_sticky_ovf  <= 1'b0;
        end else begin
            if (w_capture && alu_carryout) begin
                r_sticky_cout <= 1'b1;
            end else if (sticky_clr) begin
                r_sticky_cout <= 1'b0;
            end
            if (w_capture && alu_overflow) begin
                r_sticky_ovf <= 1'b1;
            end else if (sticky_clr) begin
                r_sticky_ovf <= 1'b0;
            end
        end
    end

    assign sticky_cout = r_sticky_cout;
    assign sticky_ovf  = r_sticky_ovf;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit; a behavioural combinational ALU stands in for the real one.
// Define ALU_STICKY_FLAGS_EN to also exercise the sticky flag ports.
`timescale 1ns/1ps
module tb_alu_issue_unit;
    import alu_issue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int SETTLE = 4;
    localparam int LAT    = SETTLE + 2;
    localparam int EXP_W  = TAG_W + 35;
    localparam longint S_MAX = 64'sh7FFF_FFFF;
    localparam longint S_MIN = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]  alu_command;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_STICKY_FLAGS_EN
    logic        sticky_clr;
    logic        sticky_cout;
    logic        sticky_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;
    int cyc     = 0;
    bit saw_full;
    logic [EXP_W-1:0] exp_q[$];
    int rsp_cyc_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    alu_issue_unit #(
        .DEPTH         (DEPTH),
        .TAG_W         (TAG_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tag      (req_tag),
        .alu_command  (alu_command),
        .alu_operandA (alu_operandA),
        .alu_operandB (alu_operandB),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_tag      (rsp_tag)
`ifdef ALU_STICKY_FLAGS_EN
        ,
        .sticky_clr   (sticky_clr),
        .sticky_cout  (sticky_cout),
        .sticky_ovf   (sticky_ovf)
`endif
    );

    // ---------------- stand-in ALU ----------------
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_command)
            CMD_ADD: begin
                alu_sum      = {1'b0, alu_operandA} + {1'b0, alu_operandB};
                alu_result   = alu_sum[31:0];
                alu_carryout = alu_sum[32];
                alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_sum[31] != alu_operandA[31]);
            end
            CMD_SUB, CMD_SLT: begin
                alu_sum      = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
                alu_carryout = alu_sum[32];
                alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_sum[31] != alu_operandA[31]);
                alu_result   = (alu_command == CMD_SUB) ? alu_sum[31:0] : {31'd0, alu_sum[31] ^ alu_overflow};
            end
            CMD_XOR:  alu_result = alu_operandA ^ alu_operandB;
            CMD_AND:  alu_result = alu_operandA & alu_operandB;
            CMD_NAND: alu_result = ~(alu_operandA & alu_operandB);
            CMD_NOR:  alu_result = ~(alu_operandA | alu_operandB);
            default:  alu_result = alu_operandA | alu_operandB;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // ---------------- reference model ----------------
    // Returns {carry, zero, overflow, result} from integer arithmetic on the operands.
    function automatic logic [34:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [31:0] res;
        logic cy, ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r = 0; res = '0; cy = 1'b0; ov = 1'b0;
        case (c)
            CMD_ADD: begin r = sa + sb; res = a + b; cy = (ua + ub) > 64'sh0_FFFF_FFFF; end
            CMD_SUB: begin r = sa - sb; res = a - b; cy = (ua >= ub); end
            CMD_SLT: begin r = sa - sb; res = (sa < sb) ? 32'd1 : 32'd0; cy = (ua >= ub); end
            CMD_XOR:  res = a ^ b;
            CMD_AND:  res = a & b;
            CMD_NAND: res = ~(a & b);
            CMD_NOR:  res = ~(a | b);
            default:  res = a | b;
        endcase
        if (c == CMD_ADD || c == CMD_SUB || c == CMD_SLT) ov = (r > S_MAX) || (r < S_MIN);
        return {cy, (res == 32'd0), ov, res};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return 128'({req_ready, alu_command, alu_operandA, alu_operandB, rsp_valid,
                     rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_tag});
    endfunction

    // Scoreboard: every accepted response is compared against the expected queue in order.
    always @(negedge clk) begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] e;
        if (!reset && rsp_valid && rsp_ready) begin
            got = {rsp_tag, rsp_carryout, rsp_zero, rsp_overflow, rsp_result};
            n_rsp++;
            rsp_cyc_q.push_back(cyc);
            check("rsp_expected_present", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_tag_flags_result", 128'(got), 128'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge with req_valid still high.
    task automatic push_req(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, input logic [EXP_W-1:0] e, output int acc_cyc);
        int k;
        req_valid = 1'b1; req_cmd = c; req_a = a; req_b = b; req_tag = t;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (req_ready) break;
            saw_full = 1'b1;
            k++;
        end
        check("push_accept_in_time", 128'(k < 200), 128'(1));
        if (k < 200) exp_q.push_back(e);
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_rsp_valid(output int at);
        int k;
        k = 0;
        at = -1;
        while (k < 100) begin
            @(negedge clk);
            if (rsp_valid) begin at = cyc; break; end
            k++;
        end
        check("rsp_valid_in_time", 128'(at >= 0), 128'(1));
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check(nm, 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int acc, at, n0;
        logic [EXP_W-1:0] snap;
        logic [2:0]  rc;
        logic [31:0] ra, rb;
        int issued, guard;
        bit accepted;
        logic [TAG_W-1:0] tag_ctr;

        vecs[0]  = '{CMD_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{CMD_SUB,  32'd7,          32'd7,          32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{CMD_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{CMD_ADD,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{CMD_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{CMD_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{CMD_NAND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{CMD_NOR,  32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{CMD_OR,   32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{CMD_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,         1'b1, 1'b0, 1'b0};
        vecs[10] = '{CMD_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0,         1'b0, 1'b1, 1'b0};
        vecs[11] = '{CMD_SLT,  32'h8000_0000,  32'd1,          32'd1,         1'b1, 1'b0, 1'b1};

        reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_a = '0; req_b = '0; req_tag = '0;
        rsp_ready = 1'b0; saw_full = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif

        // Reset state and req_ready recovery.
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", outs_vec(), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("req_ready_low_before_first_clk", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        check("req_ready_high_after_first_clk", 128'(req_ready), 128'(1));

        // Directed vectors, one at a time into an idle unit, with latency check.
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_req(vecs[i].cmd, vecs[i].a, vecs[i].b, TAG_W'(i),
                     {TAG_W'(i), vecs[i].c, vecs[i].z, vecs[i].o, vecs[i].res}, acc);
            req_valid = 1'b0;
            wait_rsp_valid(at);
            check("rsp_latency", 128'(at - acc), 128'(LAT));
            wait_drain("vector_drain");
            idle_cycles(2);
        end

        // Backpressure: response must hold while rsp_ready is low, and the queued op is not lost.
        rsp_ready = 1'b0;
        n0 = n_rsp;
        push_req(CMD_OR, 32'h0000_F0F0, 32'h0000_0F0F, 4'hA, {4'hA, 3'b000, 32'h0000_FFFF}, acc);
        req_valid = 1'b0;
        wait_rsp_valid(at);
        @(posedge clk); #1;
        push_req(CMD_ADD, 32'd3, 32'd4, 4'hB, {4'hB, ref_alu(CMD_ADD, 32'd3, 32'd4)}, acc);
        req_valid = 1'b0;
        snap = {4'hA, 3'b000, 32'h0000_FFFF};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rsp_held_under_backpressure",
                  128'({rsp_valid, rsp_tag, rsp_carryout, rsp_zero, rsp_overflow, rsp_result}),
                  128'({1'b1, snap}));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain("backpressure_drain");
        check("backpressure_rsp_count", 128'(n_rsp - n0), 128'(2));

        // Six back-to-back pushes: FIFO fills, responses in order at one per LAT cycles.
        idle_cycles(2);
        n0 = n_rsp;
        rsp_cyc_q.delete();
        saw_full = 1'b0;
        for (int t = 0; t < 6; t++) begin
            ra = $urandom(); rb = $urandom();
            push_req(CMD_ADD, ra, rb, TAG_W'(t), {TAG_W'(t), ref_alu(CMD_ADD, ra, rb)}, acc);
        end
        req_valid = 1'b0;
        check("req_ready_dropped_when_full", 128'(saw_full), 128'(1));
        wait_drain("burst_drain");
        check("burst_rsp_count", 128'(n_rsp - n0), 128'(6));
        for (int i = 1; i < 6; i++) begin
            if (rsp_cyc_q.size() == 6) check("burst_rsp_spacing", 128'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 128'(LAT));
        end
        check("burst_rsp_timestamps", 128'(rsp_cyc_q.size()), 128'(6));

        // Reset while an op is in ISSUE with three more queued.
        idle_cycles(2);
        for (int t = 0; t < 4; t++) begin
            push_req(CMD_SUB, 32'd100, 32'(t), TAG_W'(12 + t), {TAG_W'(12 + t), ref_alu(CMD_SUB, 32'd100, 32'(t))}, acc);
        end
        reset = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midop_reset_outputs_zero", outs_vec(), 128'(0));
        @(posedge clk); #1;
        n0 = n_rsp;
        reset = 1'b0;
        @(posedge clk); #1;
        check("req_ready_after_midop_reset", 128'(req_ready), 128'(1));
        idle_cycles(30);
        check("no_stale_rsp_after_reset", 128'(n_rsp - n0), 128'(0));

        // Randomized traffic with random consumer backpressure against the reference model.
        n0 = n_rsp;
        issued = 0; guard = 0; tag_ctr = '0;
        while (issued < 60 && guard < 5000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req_valid && $urandom_range(0, 2) != 0) begin
                rc = 3'($urandom_range(0, 7));
                ra = pick_operand();
                rb = ($urandom_range(0, 4) == 0) ? ra : pick_operand();
                req_valid = 1'b1; req_cmd = rc; req_a = ra; req_b = rb; req_tag = tag_ctr;
            end
            @(negedge clk);
            accepted = req_valid && req_ready;
            if (accepted) begin
                exp_q.push_back({req_tag, ref_alu(req_cmd, req_a, req_b)});
                issued++;
                tag_ctr = tag_ctr + 1'b1;
            end
            @(posedge clk); #1;
            if (accepted) req_valid = 1'b0;
            guard++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("random_all_issued", 128'(issued), 128'(60));
        wait_drain("random_drain");
        check("random_rsp_count", 128'(n_rsp - n0), 128'(60));

`ifdef ALU_STICKY_FLAGS_EN
        // Sticky flags: clear, set on overflow capture, set beats clear on the capture edge.
        idle_cycles(2);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check("sticky_cleared", 128'({sticky_cout, sticky_ovf}), 128'(0));
        push_req(CMD_ADD, 32'h7FFF_FFFF, 32'd1, 4'h1, {4'h1, 3'b001, 32'h8000_0000}, acc);
        req_valid = 1'b0;
        wait_rsp_valid(at);
        check("sticky_ovf_set", 128'({sticky_cout, sticky_ovf}), 128'(2'b01));
        wait_drain("sticky_drain_1");
        sticky_clr = 1'b1;
        push_req(CMD_ADD, 32'h7FFF_FFFF, 32'd1, 4'h2, {4'h2, 3'b001, 32'h8000_0000}, acc);
        req_valid = 1'b0;
        wait_rsp_valid(at);
        check("sticky_set_wins_over_clr", 128'(sticky_ovf), 128'(1));
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        wait_drain("sticky_drain_2");
        push_req(CMD_SUB, 32'd7, 32'd7, 4'h3, {4'h3, 3'b110, 32'h0}, acc);
        req_valid = 1'b0;
        wait_rsp_valid(at);
        check("sticky_cout_set", 128'(sticky_cout), 128'(1));
        wait_drain("sticky_drain_3");
`endif

        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
